// File: rtl/niosduino_pio_pkg.sv
// Shared register map, edge-select encoding and INFO layout for the NIOSDuino GPIO block.
package niosduino_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_DIR    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_CAP    = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;
  localparam logic [2:0] ADDR_CTRL   = 3'd6;
  localparam logic [2:0] ADDR_INFO   = 3'd7;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2,
    EDGE_OFF  = 2'd3
  } edge_sel_e;

  localparam int INFO_WIDTH_LSB = 0;
  localparam int INFO_SYNC_LSB  = 8;

endpackage

// File: rtl/niosduino_sync_edge.sv
// Pin synchroniser chain plus a delayed copy of its output for edge detection.
module niosduino_sync_edge #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q, chain_d;
  logic [WIDTH-1:0]                  s_dly_q, s_dly_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], pin};
    s_dly_d = chain_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      s_dly_q <= '0;
    end else begin
      chain_q <= chain_d;
      s_dly_q <= s_dly_d;
    end
  end

  assign sync = chain_q[SYNC_STAGES-1];
  assign rise = sync & ~s_dly_q;
  assign fall = ~sync & s_dly_q;

endmodule

// File: rtl/niosduino_pio_ext.sv
// Avalon-MM GPIO: per-bit direction, set/clear, synchronised inputs, edge capture, level IRQ.
module niosduino_pio_ext
  import niosduino_pio_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_OUT   = 32'h0,
  parameter int          RESET_EDGE  = 0
) (
  input  logic             clk_in_clk,
  input  logic             reset_reset_n,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             avs_readdatavalid,
  input  logic [WIDTH-1:0] pi_export,
  output logic [WIDTH-1:0] po_export,
  output logic [WIDTH-1:0] oe_export,
  output logic             irq
);

  localparam logic [31:0] INFO_VAL =
    (32'(WIDTH & 8'hFF) << INFO_WIDTH_LSB) | (32'(SYNC_STAGES & 8'hFF) << INFO_SYNC_LSB);

  logic [WIDTH-1:0] po_q, po_d, oe_q, oe_d, mask_q, mask_d, cap_q, cap_d;
  edge_sel_e        sel_q, sel_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d, irq_q, irq_d;
  logic [WIDTH-1:0] sync, rise, fall, edges, clr, wd;

  niosduino_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk_in_clk),
    .rst_n(reset_reset_n),
    .pin  (pi_export),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  assign wd = avs_writedata[WIDTH-1:0];

  always_comb begin
    po_d   = po_q;
    oe_d   = oe_q;
    mask_d = mask_q;
    sel_d  = sel_q;
    clr    = '0;
    if (avs_write) begin
      case (avs_address)
        ADDR_DATA:   po_d   = wd;
        ADDR_DIR:    oe_d   = wd;
        ADDR_MASK:   mask_d = wd;
        ADDR_CAP:    clr    = wd;
        ADDR_OUTSET: po_d   = po_q | wd;
        ADDR_OUTCLR: po_d   = po_q & ~wd;
        ADDR_CTRL:   sel_d  = edge_sel_e'(avs_writedata[1:0]);
        default:     ;
      endcase
    end

    // Select uses the registered edge_sel, so a CTRL write affects edges from the next cycle.
    case (sel_q)
      EDGE_RISE: edges = rise;
      EDGE_FALL: edges = fall;
      EDGE_ANY:  edges = rise | fall;
      default:   edges = '0;
    endcase
    cap_d = (cap_q & ~clr) | edges;
    irq_d = |(cap_q & mask_q);

    rdata_d = '0;
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA: rdata_d = 32'(sync);
        ADDR_DIR:  rdata_d = 32'(oe_q);
        ADDR_MASK: rdata_d = 32'(mask_q);
        ADDR_CAP:  rdata_d = 32'(cap_q);
        ADDR_CTRL: rdata_d = {30'h0, sel_q};
        ADDR_INFO: rdata_d = INFO_VAL;
        default:   rdata_d = '0;
      endcase
    end
    rvalid_d = avs_read;
  end

  always_ff @(posedge clk_in_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      po_q     <= RESET_OUT[WIDTH-1:0];
      oe_q     <= '0;
      mask_q   <= '0;
      cap_q    <= '0;
      sel_q    <= edge_sel_e'(2'(RESET_EDGE));
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      po_q     <= po_d;
      oe_q     <= oe_d;
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
    end
  end

  assign po_export         = po_q;
  assign oe_export         = oe_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = irq_q;

endmodule

// File: tb/tb_niosduino_pio_ext.sv
// Directed bench for niosduino_pio_ext: a 32-bit and an 8-bit instance on one shared bus.
module tb_niosduino_pio_ext;

  logic        clk, rst_n;
  logic [2:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata, pi;
  logic [31:0] rdata, po, oe;
  logic        rvalid, irq;
  logic [31:0] rdata8;
  logic [7:0]  po8, oe8;
  logic        rvalid8, irq8;
  int          total = 0;
  int          bad = 0;

  niosduino_pio_ext dut (
    .clk_in_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_read(rd),
    .avs_write(wr), .avs_writedata(wdata), .avs_readdata(rdata),
    .avs_readdatavalid(rvalid), .pi_export(pi), .po_export(po), .oe_export(oe), .irq(irq)
  );

  niosduino_pio_ext #(.WIDTH(8)) dut8 (
    .clk_in_clk(clk), .reset_reset_n(rst_n), .avs_address(addr), .avs_read(rd),
    .avs_write(wr), .avs_writedata(wdata), .avs_readdata(rdata8),
    .avs_readdatavalid(rvalid8), .pi_export(pi[7:0]), .po_export(po8), .oe_export(oe8),
    .irq(irq8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus(input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0; wdata = '0;
  endtask

  task automatic wrt(input logic [2:0] a, input logic [31:0] d);
    bus(1'b0, 1'b1, a, d);
  endtask

  task automatic rdchk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    bus(1'b1, 1'b0, a, '0);
    chk({tag, "_valid"}, 32'(rvalid), 32'd1);
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; pi = '0;
    #3;
    chk("rst_po", po, 32'h0);
    chk("rst_oe", oe, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    step(1);

    // Reset-state register reads
    rdchk(3'd0, 32'h0, "r_data");
    rdchk(3'd1, 32'h0, "r_dir");
    rdchk(3'd2, 32'h0, "r_mask");
    rdchk(3'd3, 32'h0, "r_cap");
    rdchk(3'd4, 32'h0, "r_outset");
    rdchk(3'd5, 32'h0, "r_outclr");
    rdchk(3'd6, 32'h0, "r_ctrl");
    rdchk(3'd7, 32'h0000_0220, "r_info");
    chk("info8", rdata8, 32'h0000_0208);
    step(1);
    chk("rvalid_drop", 32'(rvalid), 32'd0);

    // Output data: plain write, set, clear
    wrt(3'd0, 32'hF0F0_0000);
    chk("po_data", po, 32'hF0F0_0000);
    wrt(3'd4, 32'h0000_000F);
    chk("po_set", po, 32'hF0F0_000F);
    wrt(3'd5, 32'hF000_0000);
    chk("po_clr", po, 32'h00F0_000F);
    chk("po8_seq", 32'(po8), 32'h0F);

    // Same-cycle read and write returns the old value
    wrt(3'd1, 32'h0000_1234);
    bus(1'b1, 1'b1, 3'd1, 32'h0000_5678);
    chk("rw_old", rdata, 32'h0000_1234);
    chk("oe_new", oe, 32'h0000_5678);
    rdchk(3'd1, 32'h0000_5678, "rw_new");

    // Rising capture latency: DATA at t+1, CAP at t+2, irq at t+3
    wrt(3'd2, 32'h1);
    pi = 32'h1;
    step(1);
    chk("irq_t0", 32'(irq), 32'd0);
    step(1);
    rdchk(3'd0, 32'h1, "sync_data");
    chk("irq_t2", 32'(irq), 32'd0);
    rdchk(3'd3, 32'h1, "cap_rise");
    chk("irq_t3", 32'(irq), 32'd1);
    wrt(3'd3, 32'h1);
    rdchk(3'd3, 32'h0, "cap_w1c");
    chk("irq_w1c", 32'(irq), 32'd0);
    pi = 32'h0;
    step(4);
    rdchk(3'd3, 32'h0, "cap_nofall");
    chk("irq_nofall", 32'(irq), 32'd0);

    // New edge beats a same-cycle W1C of that bit
    pi = 32'h1;
    step(3);
    pi = 32'h0;
    step(3);
    pi = 32'h1;
    step(2);
    wrt(3'd3, 32'h1);
    rdchk(3'd3, 32'h1, "cap_edge_wins");
    chk("irq_held", 32'(irq), 32'd1);
    wrt(3'd3, 32'h1);
    chk("irq_lag", 32'(irq), 32'd1);
    step(1);
    chk("irq_fall", 32'(irq), 32'd0);
    rdchk(3'd3, 32'h0, "cap_clr2");

    // Any-edge, then off-mode holds existing captures; mask gates irq
    wrt(3'd6, 32'h2);
    pi = 32'h0;
    step(4);
    rdchk(3'd3, 32'h1, "cap_any_fall");
    rdchk(3'd6, 32'h2, "ctrl_any");
    wrt(3'd6, 32'hFFFF_FFF3);
    wrt(3'd2, 32'h0);
    step(1);
    chk("irq_masked", 32'(irq), 32'd0);
    pi = 32'h1;
    step(4);
    rdchk(3'd3, 32'h1, "cap_off_hold");
    wrt(3'd3, 32'h1);
    pi = 32'h0;
    step(4);
    rdchk(3'd3, 32'h0, "cap_off_none");
    rdchk(3'd6, 32'h3, "ctrl_off");

    // Width masking on the 8-bit build
    wrt(3'd0, 32'hFFFF_FFFF);
    chk("po_all", po, 32'hFFFF_FFFF);
    chk("po8_all", 32'(po8), 32'hFF);
    pi = 32'h0000_00A5;
    step(3);
    rdchk(3'd0, 32'h0000_00A5, "data_pins");
    chk("data8_pins", rdata8, 32'h0000_00A5);
    wrt(3'd1, 32'hFFFF_FFFF);
    rdchk(3'd1, 32'hFFFF_FFFF, "dir_all");
    chk("dir8_all", rdata8, 32'h0000_00FF);
    chk("oe8_all", 32'(oe8), 32'hFF);

    // Asynchronous reset pulse while a read response is pending and irq is up
    wrt(3'd6, 32'h0);
    wrt(3'd2, 32'h1);
    pi = 32'h0;
    step(3);
    pi = 32'h0000_00A5;
    step(4);
    chk("irq_pre_rst", 32'(irq), 32'd1);
    rd = 1'b1; addr = 3'd3;
    @(posedge clk);
    #1 rd = 1'b0;
    chk("rvalid_pending", 32'(rvalid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rvalid", 32'(rvalid), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_po", po, 32'h0);
    chk("arst_oe", oe, 32'h0);
    chk("arst_rdata", rdata, 32'h0);
    #1 rst_n = 1'b1;
    step(1);
    chk("post_rvalid", 32'(rvalid), 32'd0);
    rdchk(3'd2, 32'h0, "post_mask");
    rdchk(3'd1, 32'h0, "post_dir");
    rdchk(3'd6, 32'h0, "post_ctrl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
